// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/RUN/DONE sequencer with a one-cycle fetch
// register, absolute/relative branch redirect with a single squash bubble,
// stall hold and halt detection on the registered instruction.
module instr_fetch #(
  parameter int unsigned     PCW  = 10,
  parameter int unsigned     IW   = 9,
  parameter logic [IW-1:0]   HALT = '1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stall,
  input  logic           branch,
  input  logic           equal,
  input  logic           branch_rel,
  input  logic [PCW-1:0] target,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic [IW-1:0]  instr,
  output logic           instr_valid,
  output logic [PCW-1:0] instr_pc,
  output logic [PCW-1:0] pc,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [PCW-1:0] r_pc;
  logic [PCW-1:0] r_instr_pc;
  logic [IW-1:0]  r_instr;
  logic           r_valid;
  logic           r_done;

  logic [PCW-1:0] w_pc_nxt;
  logic [PCW-1:0] w_instr_pc_nxt;
  logic [IW-1:0]  w_instr_nxt;
  logic           w_valid_nxt;
  logic           w_done_nxt;

  logic           w_active;
  logic           w_halt;
  logic           w_taken;
  logic [PCW-1:0] w_branch_pc;

  // Halt outranks a taken branch; neither is looked at while stalled.
  assign w_active    = (r_state == S_RUN) && !stall;
  assign w_halt      = w_active && r_valid && (r_instr == HALT);
  assign w_taken     = w_active && r_valid && branch && equal && !w_halt;
  // Same-width add gives modulo-2^PCW wrap for negative offsets.
  assign w_branch_pc = branch_rel ? (r_instr_pc + target) : target;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_halt) w_state_nxt = S_DONE;
      S_DONE:  if (start)  w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the fetch registers for the current state and inputs.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_instr_pc_nxt = r_instr_pc;
    w_instr_nxt    = r_instr;
    w_valid_nxt    = r_valid;
    w_done_nxt     = r_done;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (start) w_pc_nxt = '0;
      end
      S_RUN: begin
        if (w_halt) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (w_taken) begin
          w_pc_nxt    = w_branch_pc;
          w_valid_nxt = 1'b0;
        end else if (w_active) begin
          w_instr_nxt    = imem_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + PCW'(1);
        end
      end
      S_DONE: begin
        w_valid_nxt = 1'b0;
        if (start) begin
          w_pc_nxt   = '0;
          w_done_nxt = 1'b0;
        end
      end
      default: begin
        w_pc_nxt    = '0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // Fetch datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= '0;
      r_instr_pc <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign done        = r_done;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized run against a
// cycle-level behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam int unsigned PCW = 10;
  localparam int unsigned IW  = 9;
  localparam logic [IW-1:0] HALT_W = 9'h1FF;

  logic           clk;
  logic           reset, start, stall, branch, equal, branch_rel;
  logic [PCW-1:0] target;
  logic [PCW-1:0] imem_addr;
  logic [IW-1:0]  imem_data;
  logic [IW-1:0]  instr;
  logic           instr_valid;
  logic [PCW-1:0] instr_pc;
  logic [PCW-1:0] pc;
  logic           done;

  logic [IW-1:0]  mem [1024];
  int checks   = 0;
  int failures = 0;

  // Behavioural model state: mode 0=idle, 1=running, 2=halted.
  int             m_mode;
  logic [PCW-1:0] m_pc, m_ipc;
  logic [IW-1:0]  m_instr;
  logic           m_valid, m_done;

  assign imem_data = mem[imem_addr];

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch(branch), .equal(equal), .branch_rel(branch_rel),
    .target(target), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .pc(pc), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_done = 1'b0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_pc = '0; end
    end else if (m_mode == 2) begin
      if (start) begin m_mode = 1; m_pc = '0; m_done = 1'b0; end
    end else if (!stall) begin
      if (m_valid && m_instr == HALT_W) begin
        m_mode = 2; m_valid = 1'b0; m_done = 1'b1;
      end else if (m_valid && branch && equal) begin
        m_pc = branch_rel ? PCW'(int'(m_ipc) + int'(target)) : target;
        m_valid = 1'b0;
      end else begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
        m_pc = PCW'(int'(m_pc) + 1);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; start = 0; stall = 0; branch = 0; equal = 0; branch_rel = 0; target = '0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = IW'(i % 256);
  endtask

  task automatic restart();
    clear_inputs();
    reset = 1; tick();
    reset = 0; start = 1; tick();
    start = 0;
  endtask

  // Step until the given address is live in instr, with a cycle budget.
  task automatic run_to(input int n);
    int k;
    k = 0;
    while (!(instr_valid === 1'b1 && instr_pc === PCW'(n)) && k < 2000) begin
      tick(); k++;
    end
    checks++;
    if (k >= 2000) begin
      failures++;
      $display("FAIL run_to_timeout target_instr_pc=%0d got instr_pc=%0d", n, instr_pc);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; start = 1; stall = 1; branch = 1; equal = 1;
    tick();
    checks++;
    if ({pc, instr, instr_pc, instr_valid, done} !== {10'd0, 9'd0, 10'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs pc=%0d instr=%h ipc=%0d v=%b done=%b exp all 0",
               pc, instr, instr_pc, instr_valid, done);
    end
    clear_inputs(); stall = 1;
    tick(); tick();
    checks++;
    if ({pc, instr_valid, done} !== {10'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_hold pc=%0d v=%b done=%b exp 0/0/0", pc, instr_valid, done);
    end
    checks++;
    if (imem_addr !== pc) begin
      failures++;
      $display("FAIL imem_addr_eq_pc got=%0d exp=%0d", imem_addr, pc);
    end
  endtask

  task automatic test_sequential();
    fill_mem();
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h1FF;
    restart();
    checks++;
    if ({pc, instr_valid} !== {10'd0, 1'b0}) begin
      failures++; $display("FAIL seq_start pc=%0d v=%b exp 0/0", pc, instr_valid);
    end
    tick();
    checks++;
    if ({instr, instr_pc, instr_valid, pc} !== {9'h001, 10'd0, 1'b1, 10'd1}) begin
      failures++; $display("FAIL seq_word0 instr=%h ipc=%0d v=%b pc=%0d exp 001/0/1/1", instr, instr_pc, instr_valid, pc);
    end
    tick();
    checks++;
    if ({instr, instr_pc, instr_valid, pc} !== {9'h002, 10'd1, 1'b1, 10'd2}) begin
      failures++; $display("FAIL seq_word1 instr=%h ipc=%0d v=%b pc=%0d exp 002/1/1/2", instr, instr_pc, instr_valid, pc);
    end
    tick();
    checks++;
    if ({instr, done} !== {9'h1FF, 1'b0}) begin
      failures++; $display("FAIL seq_halt_word instr=%h done=%b exp 1ff/0", instr, done);
    end
    tick();
    checks++;
    if ({done, instr_valid, pc} !== {1'b1, 1'b0, 10'd3}) begin
      failures++; $display("FAIL seq_done done=%b v=%b pc=%0d exp 1/0/3", done, instr_valid, pc);
    end
    stall = 1; tick(); stall = 0; tick();
    checks++;
    if ({done, instr_valid, pc} !== {1'b1, 1'b0, 10'd3}) begin
      failures++; $display("FAIL done_hold done=%b v=%b pc=%0d exp 1/0/3", done, instr_valid, pc);
    end
  endtask

  task automatic test_abs_branch();
    fill_mem();
    restart();
    run_to(3);
    branch = 1; equal = 1; branch_rel = 0; target = 10'd20;
    tick();
    clear_inputs();
    checks++;
    if ({pc, instr_valid} !== {10'd20, 1'b0}) begin
      failures++; $display("FAIL abs_branch pc=%0d v=%b exp 20/0", pc, instr_valid);
    end
    tick();
    checks++;
    if ({instr_pc, instr, instr_valid, pc} !== {10'd20, 9'd20, 1'b1, 10'd21}) begin
      failures++; $display("FAIL abs_after ipc=%0d instr=%h v=%b pc=%0d exp 20/014/1/21", instr_pc, instr, instr_valid, pc);
    end
  endtask

  task automatic test_rel_branch();
    fill_mem();
    restart();
    run_to(10);
    branch = 1; equal = 1; branch_rel = 1; target = 10'h3FC;
    tick();
    clear_inputs();
    checks++;
    if ({pc, instr_valid} !== {10'd6, 1'b0}) begin
      failures++; $display("FAIL rel_back pc=%0d v=%b exp 6/0", pc, instr_valid);
    end
    restart();
    run_to(2);
    branch = 1; equal = 1; branch_rel = 1; target = 10'h3FC;
    tick();
    clear_inputs();
    checks++;
    if ({pc, instr_valid} !== {10'd1022, 1'b0}) begin
      failures++; $display("FAIL rel_wrap pc=%0d v=%b exp 1022/0", pc, instr_valid);
    end
    tick(); tick();
    checks++;
    if ({instr_pc, pc, instr_valid} !== {10'd1023, 10'd0, 1'b1}) begin
      failures++; $display("FAIL seq_wrap ipc=%0d pc=%0d v=%b exp 1023/0/1", instr_pc, pc, instr_valid);
    end
    branch = 1; equal = 0; branch_rel = 0; target = 10'd77;
    tick();
    clear_inputs();
    checks++;
    if ({instr_pc, pc, instr_valid} !== {10'd0, 10'd1, 1'b1}) begin
      failures++; $display("FAIL not_taken ipc=%0d pc=%0d v=%b exp 0/1/1", instr_pc, pc, instr_valid);
    end
  endtask

  task automatic test_stall();
    fill_mem();
    restart();
    run_to(4);
    stall = 1; branch = 1; equal = 1; branch_rel = 0; target = 10'd40;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({pc, instr, instr_pc, instr_valid} !== {10'd5, 9'd4, 10'd4, 1'b1}) begin
        failures++; $display("FAIL stall_hold cyc=%0d pc=%0d instr=%h ipc=%0d v=%b exp 5/004/4/1", c, pc, instr, instr_pc, instr_valid);
      end
    end
    stall = 0;
    tick();
    clear_inputs();
    checks++;
    if ({pc, instr_valid} !== {10'd40, 1'b0}) begin
      failures++; $display("FAIL stall_release pc=%0d v=%b exp 40/0", pc, instr_valid);
    end
  endtask

  task automatic test_halt_vs_branch();
    fill_mem();
    mem[3] = HALT_W;
    restart();
    run_to(3);
    branch = 1; equal = 1; branch_rel = 0; target = 10'd50;
    tick();
    clear_inputs();
    checks++;
    if ({done, pc, instr_valid} !== {1'b1, 10'd4, 1'b0}) begin
      failures++; $display("FAIL halt_prio done=%b pc=%0d v=%b exp 1/4/0", done, pc, instr_valid);
    end
    start = 1; tick(); start = 0;
    checks++;
    if ({done, pc, instr_valid} !== {1'b0, 10'd0, 1'b0}) begin
      failures++; $display("FAIL restart done=%b pc=%0d v=%b exp 0/0/0", done, pc, instr_valid);
    end
    tick();
    checks++;
    if ({instr_pc, instr, instr_valid, pc} !== {10'd0, 9'd0, 1'b1, 10'd1}) begin
      failures++; $display("FAIL restart_fetch ipc=%0d instr=%h v=%b pc=%0d exp 0/000/1/1", instr_pc, instr, instr_valid, pc);
    end
  endtask

  task automatic test_reset_mid();
    fill_mem();
    restart();
    run_to(6);
    reset = 1; stall = 1; start = 1; branch = 1; equal = 1; target = 10'd99;
    tick();
    checks++;
    if ({pc, instr, instr_pc, instr_valid, done} !== {10'd0, 9'd0, 10'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_mid pc=%0d instr=%h ipc=%0d v=%b done=%b exp all 0", pc, instr, instr_pc, instr_valid, done);
    end
    clear_inputs();
    tick(); tick(); tick();
    checks++;
    if ({pc, instr_valid, done} !== {10'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_mid_idle pc=%0d v=%b done=%b exp 0/0/0", pc, instr_valid, done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? HALT_W : IW'($urandom_range(0, 510));
    clear_inputs();
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 5) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      branch     = ($urandom_range(0, 3) == 0);
      equal      = ($urandom_range(0, 1) == 0);
      branch_rel = ($urandom_range(0, 1) == 0);
      target     = PCW'($urandom);
      tick();
      checks++;
      if ({pc, imem_addr, instr, instr_pc, instr_valid, done} !==
          {m_pc, m_pc, m_instr, m_ipc, m_valid, m_done}) begin
        failures++;
        $display("FAIL random cyc=%0d pc=%0d/%0d addr=%0d instr=%h/%h ipc=%0d/%0d v=%b/%b done=%b/%b (got/exp)",
                 c, pc, m_pc, imem_addr, instr, m_instr, instr_pc, m_ipc, instr_valid, m_valid, done, m_done);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    fill_mem();
    m_mode = 0; m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_done = 1'b0;
    test_reset();
    test_sequential();
    test_abs_branch();
    test_rel_branch();
    test_stall();
    test_halt_vs_branch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PCW, default 10, program counter width in bits.
REQ-002 Parameter IW, default 9, instruction width in bits.
REQ-003 Parameter HALT, default all-ones IW-bit word, opcode that ends the program.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  pulse; begins program execution from address 0.
REQ-007 stall  input  1  hold all fetch state this cycle.
REQ-008 branch  input  1  Branch output of the control decoder for the instruction in instr.
REQ-009 equal  input  1  ALU equality flag for the instruction in instr.
REQ-010 branch_rel  input  1  1: target is a signed PC offset; 0: target is an absolute address.
REQ-011 target  input  PCW  branch target or offset.
REQ-012 imem_addr  output  PCW  instruction memory address; equals pc.
REQ-013 imem_data  input  IW  instruction memory read data, combinational from imem_addr.
REQ-014 instr  output  IW  registered instruction presented to the control decoder.
REQ-015 instr_valid  output  1  instr holds a live, unsquashed instruction.
REQ-016 instr_pc  output  PCW  address that instr was fetched from.
REQ-017 pc  output  PCW  address being fetched this cycle.
REQ-018 done  output  1  program halted.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-020 IDLE: pc held at 0, instr_valid 0; start=1 -> RUN on the next edge with pc=0.
REQ-021 RUN, stall=0, no taken branch, no halt: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
REQ-022 Fetch latency SHALL be one cycle: the word at address A appears on instr the cycle after pc=A.
REQ-023 Taken branch SHALL be branch & equal & instr_valid, evaluated in RUN with stall=0.
REQ-024 On a taken branch: pc<=(branch_rel ? instr_pc+target : target); instr_valid<=0 (the sequential fetch is squashed, one bubble).
REQ-025 Relative target SHALL be sign-extended two's complement; all PC arithmetic is modulo 2^PCW (wraps silently).
REQ-026 Sequential pc SHALL wrap from 2^PCW-1 to 0 with no flag.
REQ-027 stall=1 in RUN SHALL hold pc, instr, instr_pc, instr_valid; branch and halt are not evaluated that cycle.
REQ-028 Halt: instr_valid=1 and instr==HALT with stall=0 -> DONE next edge; instr_valid<=0, done<=1, pc held.
REQ-029 Halt SHALL take priority over a simultaneous taken branch.
REQ-030 DONE: done=1, instr_valid=0, pc held; start=1 -> RUN with pc=0, done<=0.
REQ-031 start SHALL be ignored in RUN; stall SHALL be ignored in IDLE and DONE.
REQ-032 imem_addr SHALL equal pc combinationally in every state.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, done=0, from any state, including mid-branch or mid-stall.
REQ-034 reset SHALL dominate start, stall, and branch in the same cycle.
REQ-035 All outputs SHALL be defined (no X) from the first edge after reset.

Verification
REQ-036 Sequential: reset, start, imem = {0:0x001, 1:0x002, 2:0x1FF} -> instr 0x001, 0x002 on successive cycles, then done=1 two cycles after 0x1FF is fetched.
REQ-037 Absolute branch: instr at 3 with branch=1, equal=1, branch_rel=0, target=20 -> next pc=20, one cycle instr_valid=0, then instr_pc=20.
REQ-038 Relative branch: instr_pc=10, target=-4 (PCW bits) -> pc=6; instr_pc=2, target=-4 -> pc=1022 (wrap); branch=1, equal=0 -> pc=instr_pc+2, no bubble.
REQ-039 Stall: assert stall 3 cycles at pc=5 with a taken branch pending -> pc, instr, instr_valid frozen; branch taken on the first unstalled cycle.
REQ-040 Halt vs branch: HALT word with branch=1, equal=1 -> DONE, pc not redirected; start then restarts at pc=0 with done=0.
REQ-041 Reset mid-run at pc=7 with stall=1 and start=1 -> IDLE, all outputs 0 next cycle; pc stays 0 until a later start.
